pattern_scan_ctrl: RTL and testbench

- Sequencer that feeds a serial pattern detector from a parallel word stream.
- Accepts DATA_W-bit words over a valid/ready handshake and serialises each MSB-first into an internal PAT_W-bit history register.
- Compares the history against a programmable pattern every bit and reports per-bit match pulses, a per-word match count and a saturating running total.
- Sits between a word-wide producer (FIFO/bus) and downstream status/interrupt logic.

---
 rtl/pattern_scan_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// -----------------------------------------------------------------------------
// pattern_scan_ctrl
//
// Accepts DATA_W-bit words over a valid/ready handshake and serialises each
// word MSB-first into a PAT_W-bit history register. The history is compared
// with a pattern latched at word accept on every bit. The block reports a
// registered match pulse per occurrence, the per-word match count and a
// saturating running total.
//
// History and fill persist across words, so a pattern that straddles a word
// boundary is still found. Both are cleared only by rst_n or clr.
//
// Optional build macro:
//   PAT_NO_OVERLAP_EN - when defined, a match empties the fill counter, so
//                       PAT_W fresh bits are needed before the next match
//                       (non-overlapping detection). When undefined,
//                       detection overlaps.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   rst_n        in   asynchronous active-low reset
//   clr          in   synchronous clear/abort, active-high, beats in_valid
//   cfg_pattern  in   pattern to detect, sampled only at word accept
//   in_valid     in   producer has a word
//   in_data      in   word, bit DATA_W-1 is serialised first
//   in_ready     out  block can accept a word (IDLE only)
//   match        out  one-cycle pulse per pattern occurrence
//   busy         out  word being serialised
//   done         out  one-cycle pulse after the last bit of a word
//   word_count   out  matches in the last completed word, valid while done
//   total_count  out  saturating running total of matches
// -----------------------------------------------------------------------------
module pattern_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic [PAT_W-1:0]            cfg_pattern,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  output logic                        match,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(DATA_W+1)-1:0] word_count,
  output logic [CNT_W-1:0]            total_count
);

  localparam int CW_W   = $clog2(DATA_W + 1);
  localparam int FILL_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Saturating increment for the running total: holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == {CNT_W{1'b1}}) begin
      sat_inc = val;
    end else begin
      sat_inc = val + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  state_t              state_r;
  state_t              state_s;
  logic [DATA_W-1:0]   sreg_r;
  logic [PAT_W-1:0]    hist_r;
  logic [PAT_W-1:0]    pat_q_r;
  logic [FILL_W-1:0]   fill_r;
  logic [CW_W-1:0]     bit_cnt_r;
  logic [CW_W-1:0]     word_cnt_r;
  logic [CNT_W-1:0]    total_r;
  logic                match_r;
  logic                busy_r;
  logic                done_r;
  logic                in_ready_r;

  logic                accept_s;
  logic                last_bit_s;
  logic [PAT_W-1:0]    hist_s;
  logic [FILL_W-1:0]   fill_s;
  logic                hit_s;

  // History/fill look-ahead for the bit shifted on this edge.
  always_comb begin
    accept_s   = 1'b0;
    last_bit_s = 1'b0;
    hist_s     = hist_r;
    fill_s     = fill_r;
    hit_s      = 1'b0;
    if (state_r == IDLE) begin
      accept_s = in_valid;
    end else begin
      accept_s = 1'b0;
    end
    last_bit_s = (bit_cnt_r == CW_W'(1));
    hist_s     = {hist_r[PAT_W-2:0], sreg_r[DATA_W-1]};
    if (fill_r == FILL_W'(PAT_W)) begin
      fill_s = fill_r;
    end else begin
      fill_s = fill_r + FILL_W'(1);
    end
    hit_s = (hist_s == pat_q_r) && (fill_s == FILL_W'(PAT_W));
  end

  // Next-state logic; clr wins over any handshake.
  always_comb begin
    state_s = state_r;
    if (clr) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_s = SHIFT;
          end else begin
            state_s = IDLE;
          end
        end
        SHIFT: begin
          if (last_bit_s) begin
            state_s = DONE;
          end else begin
            state_s = SHIFT;
          end
        end
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      in_ready_r <= (state_s == IDLE);
      busy_r     <= (state_s == SHIFT);
      done_r     <= (state_s == DONE);
    end
  end

  // Serialiser, detector history and match counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_r     <= '0;
      hist_r     <= '0;
      pat_q_r    <= '0;
      fill_r     <= '0;
      bit_cnt_r  <= '0;
      word_cnt_r <= '0;
      total_r    <= '0;
      match_r    <= 1'b0;
    end else if (clr) begin
      sreg_r     <= '0;
      hist_r     <= '0;
      fill_r     <= '0;
      bit_cnt_r  <= '0;
      word_cnt_r <= '0;
      total_r    <= '0;
      match_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          match_r <= 1'b0;
          if (accept_s) begin
            sreg_r     <= in_data;
            pat_q_r    <= cfg_pattern;
            bit_cnt_r  <= CW_W'(DATA_W);
            word_cnt_r <= '0;
          end else begin
            sreg_r <= sreg_r;
          end
        end
        SHIFT: begin
          sreg_r    <= {sreg_r[DATA_W-2:0], 1'b0};
          hist_r    <= hist_s;
          bit_cnt_r <= bit_cnt_r - CW_W'(1);
          match_r   <= hit_s;
          if (hit_s) begin
`ifdef PAT_NO_OVERLAP_EN
            // Non-overlapping: the matched bits cannot be reused.
            fill_r     <= '0;
`else
            fill_r     <= fill_s;
`endif
            word_cnt_r <= word_cnt_r + CW_W'(1);
            total_r    <= sat_inc(total_r);
          end else begin
            fill_r <= fill_s;
          end
        end
        DONE: begin
          match_r <= 1'b0;
        end
        default: begin
          match_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign match       = match_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign word_count  = word_cnt_r;
  assign total_count = total_r;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for pattern_scan_ctrl (DATA_W=8, PAT_W=4, CNT_W=8).
// Stimulus pushes the hand-derived result of every word that must complete:
// the per-bit match mask, word_count and total_count. A monitor collects the
// match pulses for each word and checks them against the queue head at done.
// -----------------------------------------------------------------------------
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic [3:0] cfg_pattern;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       match;
  logic       busy;
  logic       done;
  logic [3:0] word_count;
  logic [7:0] total_count;

  typedef struct packed {
    logic [8:0] mask;
    logic [3:0] wc;
    logic [7:0] tc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  time  acc_time = 0;

  pattern_scan_ctrl #(.DATA_W(8), .PAT_W(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .cfg_pattern (cfg_pattern),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .match       (match),
    .busy        (busy),
    .done        (done),
    .word_count  (word_count),
    .total_count (total_count)
  );

  always #5 clk = ~clk;

  // Expected result of one word: mask bit 7 is the match after E1.
  task automatic push(input logic [7:0] m, input int wc, input int tc);
    exp_t e;
    e.mask = {1'b0, m};
    e.wc   = 4'(wc);
    e.tc   = 8'(tc);
    exp_q.push_back(e);
  endtask

  // Present a word; returns at accept edge + 1. hold keeps in_valid high.
  task automatic send(input logic [7:0] w, input logic [3:0] p, input bit hold);
    int n;
    n = 0;
    cfg_pattern = p;
    in_data     = w;
    in_valid    = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    acc_time = $time;
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic do_clr();
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required 0", name, exp_q.size());
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({in_ready, busy, match, done, word_count, total_count} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
      errors++;
      $display("FAIL %s rdy=%0b busy=%0b match=%0b done=%0b wc=%0d tc=%0d required 1 0 0 0 0 0",
               name, in_ready, busy, match, done, word_count, total_count);
    end
  endtask

  // Monitor: gathers match pulses per word and checks at done.
  initial begin : monitor
    logic [8:0] mon_mask;
    exp_t e;
    mon_mask = 9'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mon_mask = 9'd0;
      end else if (done) begin
        mon_mask = {mon_mask[7:0], match};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done wc=%0d tc=%0d required no done", word_count, total_count);
        end else begin
          e = exp_q.pop_front();
          if ({mon_mask, word_count, total_count, busy, in_ready} !==
              {e.mask, e.wc, e.tc, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL done_word mask=%b wc=%0d tc=%0d busy=%0b rdy=%0b required mask=%b wc=%0d tc=%0d busy=0 rdy=0",
                     mon_mask, word_count, total_count, busy, in_ready, e.mask, e.wc, e.tc);
          end
        end
        mon_mask = 9'd0;
      end else if (busy) begin
        mon_mask = {mon_mask[7:0], match};
        if (in_ready !== 1'b0) begin
          checks++;
          errors++;
          $display("FAIL ready_while_busy in_ready=%0b required 0", in_ready);
        end
      end else begin
        mon_mask = 9'd0;
        checks++;
        if (in_ready !== 1'b1 || match !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs rdy=%0b match=%0b required 1 0", in_ready, match);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin : stimulus
    time t_prev;
    rst_n       = 1'b0;
    clr         = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'd0;
    cfg_pattern = 4'd0;
    #12;
    check_reset_vals("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic word from a fresh history.
`ifdef PAT_NO_OVERLAP_EN
    push(8'b0001_0000, 1, 1);
`else
    push(8'b0001_0010, 2, 2);
`endif
    send(8'b1011_0110, 4'b1011, 1'b0);
    wait_drain("basic");

    // Pattern straddling a word boundary.
    do_clr();
    push(8'b0000_0000, 0, 0);
    send(8'b0000_0101, 4'b1011, 1'b0);
    push(8'b1000_0000, 1, 1);
    send(8'b1000_0000, 4'b1011, 1'b0);
    wait_drain("boundary");

    // Back-to-back words with in_valid held high.
    do_clr();
`ifdef PAT_NO_OVERLAP_EN
    push(8'b0001_0000, 1, 1);
    push(8'b0000_0000, 0, 1);
    push(8'b1000_0000, 1, 2);
`else
    push(8'b0001_0010, 2, 2);
    push(8'b0000_0000, 0, 2);
    push(8'b1000_0000, 1, 3);
`endif
    send(8'b1011_0110, 4'b1011, 1'b1);
    t_prev = acc_time;
    send(8'b0000_0101, 4'b1011, 1'b1);
    checks++;
    if (acc_time - t_prev != 100) begin
      errors++;
      $display("FAIL accept_interval_1 got=%0t required 100", acc_time - t_prev);
    end
    t_prev = acc_time;
    send(8'b1000_0000, 4'b1011, 1'b0);
    checks++;
    if (acc_time - t_prev != 100) begin
      errors++;
      $display("FAIL accept_interval_2 got=%0t required 100", acc_time - t_prev);
    end
    wait_drain("handshake");

    // Saturation of total_count with an all-zero pattern.
    do_clr();
    for (int k = 0; k < 33; k++) begin
`ifdef PAT_NO_OVERLAP_EN
      push(8'b0001_0001, 2, 2 * (k + 1));
`else
      push((k == 0) ? 8'b0001_1111 : 8'b1111_1111, (k == 0) ? 5 : 8,
           (5 + 8 * k > 255) ? 255 : 5 + 8 * k);
`endif
      send(8'h00, 4'b0000, (k < 32) ? 1'b1 : 1'b0);
    end
    wait_drain("saturation");

    // clr on E3 of a word: word discarded, counters and fill cleared.
    send(8'h00, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_ready, busy, done, match, total_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL clr_midword rdy=%0b busy=%0b done=%0b match=%0b tc=%0d required 1 0 0 0 0",
               in_ready, busy, done, match, total_count);
    end
    clr = 1'b0;
`ifdef PAT_NO_OVERLAP_EN
    push(8'b0001_0001, 2, 2);
`else
    push(8'b0001_1111, 5, 5);
`endif
    send(8'h00, 4'b0000, 1'b0);
    wait_drain("after_clr");

    // Asynchronous reset between edges while shifting.
    send(8'h00, 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
`ifdef PAT_NO_OVERLAP_EN
    push(8'b0001_0000, 1, 1);
`else
    push(8'b0001_0010, 2, 2);
`endif
    send(8'b1011_0110, 4'b1011, 1'b0);
    wait_drain("after_reset");

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
